// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one transaction at a time, fixed read latency, single response pulse.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-break; otherwise the core has fixed priority.
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_wr,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic [2:0]    core_func3,
    output logic          core_gnt,
    output logic          core_rvalid,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [2:0]    dma_func3,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic          rerr,
    output logic          mem_read,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_func3,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    localparam logic [2:0] LAT      = 3'(RD_LAT);

    logic [1:0]    r_state;
    logic          r_owner_core;
    logic [2:0]    r_lat_cnt;
    logic          r_wr;
    logic          r_misal;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [2:0]    r_func3;

    logic          w_idle;
    logic          w_pick_core;
    logic          w_pick_dma;
    logic          w_accept;
    logic          w_sel_wr;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic [2:0]    w_sel_func3;
    logic          w_drive;
    logic          w_capture;

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    assign w_idle = (r_state == S_IDLE);

`ifdef DMEM_ARB_RR_EN
    // On a tie the requester that did not own the last transaction wins.
    assign w_pick_core = core_req & (~dma_req | ~r_owner_core);
`else
    assign w_pick_core = core_req;
`endif
    assign w_pick_dma  = dma_req & ~w_pick_core;

    assign core_gnt = w_idle & w_pick_core;
    assign dma_gnt  = w_idle & w_pick_dma;
    assign w_accept = core_gnt | dma_gnt;

    assign w_sel_wr    = w_pick_core ? core_wr    : dma_wr;
    assign w_sel_addr  = w_pick_core ? core_addr  : dma_addr;
    assign w_sel_wdata = w_pick_core ? core_wdata : dma_wdata;
    assign w_sel_func3 = w_pick_core ? core_func3 : dma_func3;

    assign w_capture = ((r_state == S_ACCESS) && !r_misal && !r_wr && (LAT == 3'd0)) ||
                       ((r_state == S_WAIT) && (r_lat_cnt == 3'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner_core <= 1'b0;
            r_lat_cnt    <= 3'd0;
            r_wr         <= 1'b0;
            r_misal      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner_core <= w_pick_core;
                        r_wr         <= w_sel_wr;
                        r_misal      <= f_misaligned(w_sel_func3, w_sel_addr[1:0]);
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_misal || r_wr || (LAT == 3'd0)) begin
                        r_state <= S_RESP;
                    end else begin
                        r_lat_cnt <= LAT;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == 3'd1) begin
                        r_lat_cnt <= 3'd0;
                        r_state   <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request fields and read data need no reset: every output using them is gated by state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_func3 <= w_sel_func3;
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= mem_rdata;
        end
    end

    assign w_drive   = (r_state == S_ACCESS) || (r_state == S_WAIT);
    assign mem_read  = ((r_state == S_ACCESS) && !r_misal && !r_wr) || (r_state == S_WAIT);
    assign mem_wr    = (r_state == S_ACCESS) && !r_misal && r_wr;
    assign mem_addr  = w_drive ? r_addr  : '0;
    assign mem_wdata = w_drive ? r_wdata : '0;
    assign mem_func3 = w_drive ? r_func3 : 3'd0;

    assign core_rvalid = (r_state == S_RESP) && r_owner_core;
    assign dma_rvalid  = (r_state == S_RESP) && !r_owner_core;
    assign rdata       = (r_state == S_RESP) ? r_rdata : '0;
    assign rerr        = (r_state == S_RESP) && r_misal;
    assign busy        = !w_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=0 and RD_LAT=3), each with its own word memory.
// Expected behaviour comes from a transaction-level model (latency formulas, word array, owner bit).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        core_req [2], core_wr [2], core_gnt [2], core_rvalid [2];
    logic [31:0] core_addr [2], core_wdata [2];
    logic [2:0]  core_func3 [2];
    logic        dma_req [2], dma_wr [2], dma_gnt [2], dma_rvalid [2];
    logic [31:0] dma_addr [2], dma_wdata [2];
    logic [2:0]  dma_func3 [2];
    logic [31:0] rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        rerr [2], mem_read [2], mem_wr [2], busy [2];
    logic [2:0]  mem_func3 [2];

    int comps = 0;
    int fails = 0;
    logic [31:0] ref_mem [2][64];
    bit ref_last_dma;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : 3;
        logic [31:0] mem [64];
        int rd_cyc;

        dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .core_req(core_req[g]), .core_wr(core_wr[g]), .core_addr(core_addr[g]),
            .core_wdata(core_wdata[g]), .core_func3(core_func3[g]),
            .core_gnt(core_gnt[g]), .core_rvalid(core_rvalid[g]),
            .dma_req(dma_req[g]), .dma_wr(dma_wr[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_func3(dma_func3[g]),
            .dma_gnt(dma_gnt[g]), .dma_rvalid(dma_rvalid[g]),
            .rdata(rdata[g]), .rerr(rerr[g]),
            .mem_read(mem_read[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_func3(mem_func3[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g])
        );

        // Memory returns garbage until the read strobe has been high for L cycles.
        always @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
                rd_cyc <= 0;
            end else begin
                if (mem_wr[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
                rd_cyc <= mem_read[g] ? rd_cyc + 1 : 0;
            end
        end
        assign mem_rdata[g] = (rd_cyc == L) ? mem[mem_addr[g][7:2]] : (32'hBAD0_0000 | 32'(rd_cyc));
    end

    function automatic bit model_misal(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b01) return a[0];
        if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++) begin
            core_req[d] = 0; core_wr[d] = 0; core_addr[d] = 0; core_wdata[d] = 0; core_func3[d] = 0;
            dma_req[d] = 0;  dma_wr[d] = 0;  dma_addr[d] = 0;  dma_wdata[d] = 0;  dma_func3[d] = 0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) ref_mem[d][i] = 32'hC0DE_0000 + 32'(i);
        ref_last_dma = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Runs one transaction from a requester and reports what was observed (offsets relative to grant cycle).
    task automatic txn(input int d, input bit dma, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       output int gw, output int fs, output int ns, output int ra,
                       output logic [31:0] rd, output logic re, output int bad);
        gw = -1; fs = -1; ns = 0; ra = -1; rd = '0; re = 1'b0; bad = 0;
        if (!dma) begin
            core_req[d] = 1; core_wr[d] = wr; core_addr[d] = addr; core_wdata[d] = wdata; core_func3[d] = f3;
        end else begin
            dma_req[d] = 1; dma_wr[d] = wr; dma_addr[d] = addr; dma_wdata[d] = wdata; dma_func3[d] = f3;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dma ? dma_gnt[d] : core_gnt[d]) begin gw = k; break; end
        end
        @(posedge clk);
        #1;
        if (!dma) core_req[d] = 0; else dma_req[d] = 0;
        if (gw >= 0) begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (mem_read[d] && mem_wr[d]) bad++;
                if (mem_read[d] || mem_wr[d]) begin
                    if (fs < 0) fs = k;
                    ns++;
                    if (mem_addr[d] !== addr) bad++;
                end
                if (dma ? core_rvalid[d] : dma_rvalid[d]) bad++;
                if (dma ? dma_rvalid[d] : core_rvalid[d]) begin
                    ra = k; rd = rdata[d]; re = rerr[d];
                    if (mem_addr[d] !== 32'h0) bad++;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            comps++;
            if ({busy[d], core_gnt[d], dma_gnt[d], core_rvalid[d], dma_rvalid[d], mem_read[d], mem_wr[d], rerr[d]} !== 8'h0 ||
                rdata[d] !== 32'h0 || mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
                fails++;
                $display("FAIL reset_state[%0d]: busy=%b rv=%b%b strobes=%b%b rdata=%h addr=%h required all zero",
                         d, busy[d], core_rvalid[d], dma_rvalid[d], mem_read[d], mem_wr[d], rdata[d], mem_addr[d]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int gw, fs, ns, ra, bad; logic [31:0] rd; logic re;
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, gw, fs, ns, ra, rd, re, bad);
        ref_mem[0][4] = 32'hDEADBEEF;
        comps++;
        if (gw !== 0 || fs !== 1 || ns !== 1 || ra !== 2 || rd !== 32'h0 || re !== 1'b0 || bad !== 0) begin
            fails++;
            $display("FAIL core_sw: gnt=%0d strobe=%0d n=%0d rvalid=%0d rdata=%h rerr=%b bad=%0d required 0 1 1 2 0 0 0",
                     gw, fs, ns, ra, rd, re, bad);
        end
        txn(0, 0, 0, 32'h10, 32'h0, 3'b010, gw, fs, ns, ra, rd, re, bad);
        comps++;
        if (ra !== 2 || rd !== 32'hDEADBEEF || re !== 1'b0 || bad !== 0) begin
            fails++;
            $display("FAIL core_lw: rvalid=%0d rdata=%h rerr=%b bad=%0d required 2 deadbeef 0 0", ra, rd, re, bad);
        end
    endtask

    task automatic test_lat3_load();
        int gw, fs, ns, ra, bad; logic [31:0] rd; logic re;
        txn(1, 1, 0, 32'h20, 32'h0, 3'b010, gw, fs, ns, ra, rd, re, bad);
        comps++;
        if (gw !== 0 || fs !== 1 || ns !== 4 || ra !== 5 || rd !== ref_mem[1][8] || re !== 1'b0 || bad !== 0) begin
            fails++;
            $display("FAIL dma_lw_lat3: gnt=%0d strobe=%0d n=%0d rvalid=%0d rdata=%h bad=%0d required 0 1 4 5 %h 0",
                     gw, fs, ns, ra, rd, bad, ref_mem[1][8]);
        end
    endtask

    task automatic test_misaligned();
        int gw, fs, ns, ra, bad; logic [31:0] rd; logic re;
        txn(0, 0, 0, 32'h13, 32'h0, 3'b001, gw, fs, ns, ra, rd, re, bad);
        comps++;
        if (ns !== 0 || ra !== 2 || rd !== 32'h0 || re !== 1'b1 || bad !== 0) begin
            fails++;
            $display("FAIL core_lh_misaligned: n=%0d rvalid=%0d rdata=%h rerr=%b bad=%0d required 0 2 0 1 0",
                     ns, ra, rd, re, bad);
        end
    endtask

    task automatic test_random();
        int gw, fs, ns, ra, bad, lat, d;
        bit dma, wr, mis;
        logic [31:0] rd, addr, wdata, exp_rd;
        logic re;
        logic [2:0] f3;
        logic [2:0] codes [5];
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 40; n++) begin
            d     = int'($urandom_range(0, 1));
            lat   = (d == 0) ? 0 : 3;
            dma   = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            f3    = codes[$urandom_range(0, 4)];
            addr  = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            wdata = $urandom;
            mis   = model_misal(f3, addr);
            exp_rd = (mis || wr) ? 32'h0 : ref_mem[d][addr[7:2]];
            txn(d, dma, wr, addr, wdata, f3, gw, fs, ns, ra, rd, re, bad);
            if (wr && !mis) ref_mem[d][addr[7:2]] = wdata;
            comps++;
            if (gw !== 0 || fs !== (mis ? -1 : 1) || ns !== (mis ? 0 : (wr ? 1 : 1 + lat)) ||
                ra !== ((mis || wr) ? 2 : 2 + lat) || rd !== exp_rd || re !== mis || bad !== 0) begin
                fails++;
                $display("FAIL random[%0d] d=%0d dma=%b wr=%b a=%h f3=%b: gnt=%0d strobe=%0d n=%0d rvalid=%0d rdata=%h rerr=%b bad=%0d required rdata=%h rerr=%b",
                         n, d, dma, wr, addr, f3, gw, fs, ns, ra, rd, re, bad, exp_rd, mis);
            end
        end
    endtask

    task automatic test_arbitration();
        bit exp_dma, got_dma, seen;
        do_reset();
        core_req[0] = 1; core_wr[0] = 0; core_addr[0] = 32'h40; core_func3[0] = 3'b010;
        dma_req[0]  = 1; dma_wr[0]  = 0; dma_addr[0]  = 32'h44; dma_func3[0]  = 3'b010;
        for (int n = 0; n < 4; n++) begin
`ifdef DMEM_ARB_RR_EN
            exp_dma = !ref_last_dma;
`else
            exp_dma = 1'b0;
`endif
            seen = 0; got_dma = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (core_gnt[0] || dma_gnt[0]) begin seen = 1; got_dma = dma_gnt[0] && !core_gnt[0]; end
            end
            comps++;
            if (!seen || got_dma !== exp_dma) begin
                fails++;
                $display("FAIL arb_grant[%0d]: granted %s required %s", n,
                         !seen ? "none" : (got_dma ? "dma" : "core"), exp_dma ? "dma" : "core");
            end
            ref_last_dma = exp_dma;
            @(posedge clk);
            #1;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (core_rvalid[0] || dma_rvalid[0]) seen = 1;
            end
            @(posedge clk);
            #1;
        end
        core_req[0] = 0; dma_req[0] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_block();
        int rc, gc;
        bit seen;
        core_req[1] = 1; core_wr[1] = 0; core_addr[1] = 32'h30; core_func3[1] = 3'b010;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (core_gnt[1]) seen = 1;
        end
        @(posedge clk);
        #1 core_req[1] = 0;
        @(posedge clk);
        #1;
        dma_req[1] = 1; dma_wr[1] = 0; dma_addr[1] = 32'h34; dma_func3[1] = 3'b010;
        rc = -1; gc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (core_rvalid[1]) rc = k;
            if (dma_gnt[1]) begin gc = k; break; end
        end
        comps++;
        if (!seen || rc !== 4 || gc !== 5) begin
            fails++;
            $display("FAIL dma_wait_during_core: core_rvalid at %0d dma_gnt at %0d required 4 and 5", rc, gc);
        end
        @(posedge clk);
        #1 dma_req[1] = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dma_rvalid[1]) begin
                seen = 1;
                comps++;
                if (rdata[1] !== ref_mem[1][13]) begin
                    fails++;
                    $display("FAIL dma_after_wait_rdata: %h required %h", rdata[1], ref_mem[1][13]);
                end
            end
        end
        comps++;
        if (!seen) begin
            fails++;
            $display("FAIL dma_after_wait_rvalid: none within bound, required one");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int stray;
        bit seen;
        dma_req[1] = 1; dma_wr[1] = 0; dma_addr[1] = 32'h24; dma_func3[1] = 3'b010;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dma_gnt[1]) seen = 1;
        end
        @(posedge clk);
        #1 dma_req[1] = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        comps++;
        if (!seen || mem_read[1] !== 1'b1 || busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL abort_in_wait: gnt=%b mem_read=%b busy=%b required 1 1 1", seen, mem_read[1], busy[1]);
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        comps++;
        if (mem_read[1] !== 1'b0 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL abort_strobe_drop: mem_read=%b busy=%b required 0 0", mem_read[1], busy[1]);
        end
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (core_rvalid[1] || dma_rvalid[1]) stray++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (core_rvalid[1] || dma_rvalid[1] || busy[1]) stray++;
        end
        comps++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL abort_no_rvalid: %0d stray rvalid/busy cycles, required 0", stray);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_reqs();
        do_reset();
        test_reset();
        test_store_load();
        test_lat3_load();
        test_misaligned();
        test_random();
        test_arbitration();
        test_back_to_back_block();
        test_reset_abort();
        test_store_load();
        $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
